instr_sequencer: RTL and testbench

//  Upstream fetch/issue stage for the PlayBus level 1 controller.
//  - Fetches 8-bit instruction words from a synchronous program ROM and keeps the program counter.
//  - Decodes HALT and JMP locally.
//  - Presents every other opcode on func[2:0] for exactly one controller "start"-state cycle.
//  - Inserts a NOP gap after XFER_OP so the controller's two-cycle transfer is never overrun.

---
 rtl/instr_sequencer_if.sv | 37 +++
 rtl/instr_sequencer.sv | 155 +++++++++++++++
 tb/tb_instr_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer, its program ROM and the
// PlayBus level 1 controller.
// The sequencer uses the master modport. The ROM/controller side uses the slave modport.
interface instr_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int OPER_W = 5
);

  logic              run;
  logic [ADDR_W-1:0] rom_addr;
  logic [OPER_W+2:0] rom_data;
  logic [2:0]        func;
  logic [OPER_W-1:0] operand;
  logic              func_valid;
  logic              halted;

  modport master (
    input  run,
    input  rom_data,
    output rom_addr,
    output func,
    output operand,
    output func_valid,
    output halted
  );

  modport slave (
    output run,
    output rom_data,
    input  rom_addr,
    input  func,
    input  operand,
    input  func_valid,
    input  halted
  );

endinterface

// File: rtl/instr_sequencer.sv
// Fetch/issue stage for the PlayBus level 1 controller.
// The program ROM is synchronous, so every instruction takes a FETCH cycle
// (address out) and a LOAD cycle (word back, decoded).
// HALT and JMP are resolved in LOAD and never reach the controller.
// Every other opcode is issued for exactly one EXEC cycle.
// XFER_OP is followed by one GAP cycle so the controller's two-cycle transfer
// is not overrun.
// All controller-facing outputs come from flops loaded with the next-state
// values, so there is no combinational path from rom_data or run to them.
// rom_addr is the PC register itself.
// OPER_W must be at least ADDR_W: the JMP target is the low ADDR_W bits of
// the operand.
module instr_sequencer #(
  parameter int         ADDR_W  = 5,
  parameter int         OPER_W  = 5,
  parameter logic [2:0] HALT_OP = 3'd0,
  parameter logic [2:0] JMP_OP  = 3'd7,
  parameter logic [2:0] XFER_OP = 3'd5
) (
  input  logic              clk,
  input  logic              n_reset,
  instr_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_EXEC   = 3'd3,
    S_GAP    = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  // Opcode half of the instruction register.
  // The operand half lives in operand_q, which changes only on issue.
  logic [2:0]        ir_op_q, ir_op_d;
  logic [2:0]        func_q, func_d;
  logic [OPER_W-1:0] operand_q, operand_d;
  logic              func_valid_q, func_valid_d;
  logic              halted_q, halted_d;

  logic [2:0]        rom_op_s;
  logic [OPER_W-1:0] rom_opnd_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] jmp_tgt_s;
  state_e            resume_s;

  assign rom_op_s   = bus.rom_data[OPER_W+2:OPER_W];
  assign rom_opnd_s = bus.rom_data[OPER_W-1:0];
  // The PC wraps modulo 2**ADDR_W through natural overflow.
  assign pc_inc_s   = pc_q + ADDR_W'(1);
  // Operand bits above ADDR_W are ignored for jumps.
  assign jmp_tgt_s  = rom_opnd_s[ADDR_W-1:0];
  // At an instruction boundary, go on fetching only while run is high.
  assign resume_s   = bus.run ? S_FETCH : S_IDLE;

  // Registers for state, PC, IR, and the controller-facing outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      ir_op_q      <= 3'd0;
      func_q       <= 3'd0;
      operand_q    <= '0;
      func_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_op_q      <= ir_op_d;
      func_q       <= func_d;
      operand_q    <= operand_d;
      func_valid_q <= func_valid_d;
      halted_q     <= halted_d;
    end
  end

  // Next-state logic.
  // Output flops are loaded with the values that belong to the state being entered.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_op_d      = ir_op_q;
    func_d       = 3'd0;
    operand_d    = operand_q;
    func_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        ir_op_d = rom_op_s;
        if (rom_op_s == HALT_OP) begin
          pc_d    = pc_inc_s;
          state_d = S_HALTED;
        end else if (rom_op_s == JMP_OP) begin
          pc_d    = jmp_tgt_s;
          state_d = resume_s;
        end else begin
          // Issue: the EXEC cycle is the one that shows func_valid.
          state_d      = S_EXEC;
          func_d       = rom_op_s;
          operand_d    = rom_opnd_s;
          func_valid_d = 1'b1;
        end
      end

      S_EXEC: begin
        pc_d = pc_inc_s;
        if (ir_op_q == XFER_OP) begin
          state_d = S_GAP;
        end else begin
          state_d = resume_s;
        end
      end

      S_GAP: begin
        state_d = resume_s;
      end

      S_HALTED: begin
        if (bus.run) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    halted_d = (state_d == S_HALTED);
  end

  assign bus.rom_addr   = pc_q;
  assign bus.func       = func_q;
  assign bus.operand    = operand_q;
  assign bus.func_valid = func_valid_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer.
// It models a synchronous 32x8 program ROM and drives run and n_reset at the
// falling edge. Outputs are sampled at the falling edge.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] rom [0:31];
  int         n_checks = 0;
  int         n_fail = 0;
  int         pulses;

  instr_sequencer_if #(.ADDR_W(5), .OPER_W(5)) bus ();

  instr_sequencer #(
    .ADDR_W (5),
    .OPER_W (5)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM: the word appears the cycle after the address.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 32; i++) rom[i] = 8'h20;   // opcode 1, operand 0
  endtask

  task automatic do_reset();
    bus.run = 1'b0;
    n_reset = 1'b0;
    step(2);
    check_val("rst_func",    {29'd0, bus.func},       32'd0);
    check_val("rst_operand", {27'd0, bus.operand},    32'd0);
    check_val("rst_valid",   {31'd0, bus.func_valid}, 32'd0);
    check_val("rst_halted",  {31'd0, bus.halted},     32'd0);
    check_val("rst_addr",    {27'd0, bus.rom_addr},   32'd0);
    n_reset = 1'b1;
    step(1);
  endtask

  initial begin
    bus.run = 1'b0;
    n_reset = 1'b0;
    fill_nop();

    // T2: a single issue, 3 cycles after run, lasting exactly one cycle.
    rom[0] = 8'h49;                       // {2, 9}
    do_reset();
    bus.run = 1'b1;
    step(1);
    check_val("t2_fetch_valid", {31'd0, bus.func_valid}, 32'd0);
    step(1);
    check_val("t2_load_valid",  {31'd0, bus.func_valid}, 32'd0);
    step(1);
    check_val("t2_exec_valid",  {31'd0, bus.func_valid}, 32'd1);
    check_val("t2_exec_func",   {29'd0, bus.func},       32'd2);
    check_val("t2_exec_oper",   {27'd0, bus.operand},    32'd9);
    bus.run = 1'b0;
    step(1);
    check_val("t2_after_valid", {31'd0, bus.func_valid}, 32'd0);
    check_val("t2_after_func",  {29'd0, bus.func},       32'd0);
    check_val("t2_held_oper",   {27'd0, bus.operand},    32'd9);
    check_val("t2_pc_inc",      {27'd0, bus.rom_addr},   32'd1);

    // T1: asynchronous reset in the middle of EXEC.
    do_reset();
    bus.run = 1'b1;
    step(3);
    check_val("t1_exec_valid", {31'd0, bus.func_valid}, 32'd1);
    n_reset = 1'b0;
    #1;
    check_val("t1_async_valid", {31'd0, bus.func_valid}, 32'd0);
    check_val("t1_async_func",  {29'd0, bus.func},       32'd0);
    check_val("t1_async_oper",  {27'd0, bus.operand},    32'd0);
    check_val("t1_async_addr",  {27'd0, bus.rom_addr},   32'd0);
    bus.run = 1'b0;
    step(1);
    n_reset = 1'b1;
    step(2);
    check_val("t1_idle_valid", {31'd0, bus.func_valid}, 32'd0);
    check_val("t1_idle_addr",  {27'd0, bus.rom_addr},   32'd0);

    // T3: XFER is followed by a GAP cycle, so issues are 4 cycles apart.
    fill_nop();
    rom[0] = 8'hA3;                       // {5, 3}
    rom[1] = 8'h44;                       // {2, 4}
    do_reset();
    bus.run = 1'b1;
    step(3);
    check_val("t3_x_valid", {31'd0, bus.func_valid}, 32'd1);
    check_val("t3_x_func",  {29'd0, bus.func},       32'd5);
    check_val("t3_x_oper",  {27'd0, bus.operand},    32'd3);
    step(1);
    check_val("t3_gap_valid", {31'd0, bus.func_valid}, 32'd0);
    check_val("t3_gap_func",  {29'd0, bus.func},       32'd0);
    check_val("t3_gap_addr",  {27'd0, bus.rom_addr},   32'd1);
    step(1);
    check_val("t3_fetch_valid", {31'd0, bus.func_valid}, 32'd0);
    step(1);
    check_val("t3_load_valid",  {31'd0, bus.func_valid}, 32'd0);
    step(1);
    check_val("t3_2nd_valid", {31'd0, bus.func_valid}, 32'd1);
    check_val("t3_2nd_func",  {29'd0, bus.func},       32'd2);
    check_val("t3_2nd_oper",  {27'd0, bus.operand},    32'd4);
    bus.run = 1'b0;
    step(2);

    // T4: JMP at address 3 to address 1, which takes 2 cycles and issues nothing.
    fill_nop();
    rom[3] = 8'hE1;                       // {7, 1}
    do_reset();
    bus.run = 1'b1;
    step(10);
    check_val("t4_fetch_addr", {27'd0, bus.rom_addr}, 32'd3);
    step(1);
    check_val("t4_load_addr",  {27'd0, bus.rom_addr}, 32'd3);
    check_val("t4_load_valid", {31'd0, bus.func_valid}, 32'd0);
    step(1);
    check_val("t4_tgt_addr",   {27'd0, bus.rom_addr}, 32'd1);
    check_val("t4_tgt_valid",  {31'd0, bus.func_valid}, 32'd0);
    step(2);
    check_val("t4_tgt_issue",  {31'd0, bus.func_valid}, 32'd1);
    check_val("t4_tgt_func",   {29'd0, bus.func},       32'd1);
    bus.run = 1'b0;
    step(2);

    // T4b: a jump to its own address loops without ever raising func_valid.
    fill_nop();
    rom[0] = 8'hE0;                       // {7, 0}
    do_reset();
    bus.run = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus.func_valid) pulses++;
      if (bus.rom_addr != 5'd0) pulses += 100;
    end
    check_val("t4b_self_loop", pulses, 32'd0);
    bus.run = 1'b0;
    step(3);

    // T5: HALT at address 4, then restart at address 5.
    fill_nop();
    rom[4] = 8'h00;                       // HALT
    rom[5] = 8'h47;                       // {2, 7}
    do_reset();
    bus.run = 1'b1;
    step(15);
    check_val("t5_halted",  {31'd0, bus.halted},   32'd1);
    check_val("t5_pc",      {27'd0, bus.rom_addr}, 32'd5);
    step(3);
    check_val("t5_stay",    {31'd0, bus.halted},     32'd1);
    check_val("t5_novalid", {31'd0, bus.func_valid}, 32'd0);
    bus.run = 1'b0;
    step(1);
    check_val("t5_idle_halted", {31'd0, bus.halted},   32'd0);
    check_val("t5_idle_pc",     {27'd0, bus.rom_addr}, 32'd5);
    bus.run = 1'b1;
    step(1);
    check_val("t5_resume_addr", {27'd0, bus.rom_addr}, 32'd5);
    step(2);
    check_val("t5_resume_valid", {31'd0, bus.func_valid}, 32'd1);
    check_val("t5_resume_func",  {29'd0, bus.func},       32'd2);
    check_val("t5_resume_oper",  {27'd0, bus.operand},    32'd7);
    bus.run = 1'b0;
    step(2);

    // T6: a NOP at 31 wraps the PC to 0. run drops during LOAD and the
    // instruction still issues.
    fill_nop();
    rom[0]  = 8'hFF;                      // {7, 31}
    rom[31] = 8'h2A;                      // {1, 10}
    do_reset();
    bus.run = 1'b1;
    step(3);
    check_val("t6_fetch31", {27'd0, bus.rom_addr}, 32'd31);
    step(1);
    bus.run = 1'b0;                       // currently in LOAD
    step(1);
    check_val("t6_issue_valid", {31'd0, bus.func_valid}, 32'd1);
    check_val("t6_issue_func",  {29'd0, bus.func},       32'd1);
    check_val("t6_issue_oper",  {27'd0, bus.operand},    32'd10);
    step(1);
    check_val("t6_wrap_addr",  {27'd0, bus.rom_addr},   32'd0);
    check_val("t6_stop_valid", {31'd0, bus.func_valid}, 32'd0);
    step(3);
    check_val("t6_idle_addr",  {27'd0, bus.rom_addr},   32'd0);
    check_val("t6_idle_valid", {31'd0, bus.func_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
